// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: register-file geometry and the write-back entry type.
package kgp_risc_pkg;
  localparam int KGP_AW = 5;
  localparam int KGP_DW = 32;

  typedef struct packed {
    logic [KGP_AW-1:0] rd;
    logic [KGP_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_writeback_queue_if.sv
// Bundle of request, register-file write port, forwarding and status signals
// for the write-back queue.
interface rf_writeback_queue_if
  import kgp_risc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = KGP_AW,
  parameter int DW    = KGP_DW
);
  localparam int CW = $clog2(DEPTH) + 1;

  // A request is taken on a posedge where its valid and ready are both 1.
  // Ready never looks at the same-cycle pop, and memory beats ALU when both are valid.
  logic          mem_valid;
  logic [AW-1:0] mem_reg;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          hold;
  logic          flush;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] fwd_addr1;
  logic [AW-1:0] fwd_addr2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           hold, flush, fwd_addr1, fwd_addr2,
    input  mem_ready, alu_ready, reg_write, write_reg, write_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, full, empty
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
           hold, flush, fwd_addr1, fwd_addr2,
    output mem_ready, alu_ready, reg_write, write_reg, write_data,
           fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, full, empty
  );
endinterface

// File: rtl/rf_wb_fwd_match.sv
// Priority address compare over NS slots ordered oldest (index 0) to newest;
// the highest-index valid match supplies the forwarded data.
module rf_wb_fwd_match
  import kgp_risc_pkg::*;
#(
  parameter int NS = 5,
  parameter int AW = KGP_AW,
  parameter int DW = KGP_DW
) (
  input  logic [AW-1:0]         addr,
  input  logic [NS-1:0]         slot_valid,
  input  logic [NS-1:0][AW-1:0] slot_rd,
  input  logic [NS-1:0][DW-1:0] slot_data,
  output logic                  hit,
  output logic [DW-1:0]         data
);
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NS; i++) begin
      if (slot_valid[i] && (slot_rd[i] == addr)) begin
        hit  = 1'b1;
        data = slot_data[i];
      end
    end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// Write-back FIFO between the ALU/memory paths and the register file's single
// write port, with two-port forwarding of not-yet-committed writes.
module rf_writeback_queue
  import kgp_risc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = KGP_AW,
  parameter int DW    = KGP_DW
) (
  input  logic            clk,
  input  logic            rst,
  rf_writeback_queue_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NS = DEPTH + 1;

  logic [AW-1:0] q_rd   [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic          full_w;
  logic          empty_w;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_rd;
  logic [DW-1:0] push_data;

  logic          reg_write_q;
  logic [AW-1:0] write_reg_q;
  logic [DW-1:0] write_data_q;

  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign push      = !wb.flush && !full_w && (wb.mem_valid || wb.alu_valid);
  assign pop       = !wb.flush && !wb.hold && !empty_w;
  assign push_rd   = wb.mem_valid ? wb.mem_reg  : wb.alu_reg;
  assign push_data = wb.mem_valid ? wb.mem_data : wb.alu_data;

  assign wb.mem_ready  = !full_w;
  assign wb.alu_ready  = !full_w && !wb.mem_valid;
  assign wb.count      = count_q;
  assign wb.full       = full_w;
  assign wb.empty      = empty_w;
  assign wb.reg_write  = reg_write_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else if (wb.flush) begin
      // The output stage already went to the register file; only the queue is dropped.
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q     <= count_q + CW'(push) - CW'(pop);
      reg_write_q <= pop;
      if (pop) begin
        write_reg_q  <= q_rd[rd_ptr];
        write_data_q <= q_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= push_rd;
      q_data[wr_ptr] <= push_data;
    end
  end

  // Slot 0 is the output stage (oldest); slots 1..DEPTH run head to tail.
  logic [NS-1:0]         slot_valid;
  logic [NS-1:0][AW-1:0] slot_rd;
  logic [NS-1:0][DW-1:0] slot_data;

  always_comb begin
    slot_valid    = '0;
    slot_rd       = '0;
    slot_data     = '0;
    slot_valid[0] = reg_write_q;
    slot_rd[0]    = write_reg_q;
    slot_data[0]  = write_data_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k+1] = (CW'(k) < count_q);
      slot_rd[k+1]    = q_rd[rd_ptr + PW'(k)];
      slot_data[k+1]  = q_data[rd_ptr + PW'(k)];
    end
  end

  rf_wb_fwd_match #(.NS(NS), .AW(AW), .DW(DW)) u_fwd1 (
    .addr       (wb.fwd_addr1),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd),
    .slot_data  (slot_data),
    .hit        (wb.fwd_hit1),
    .data       (wb.fwd_data1)
  );

  rf_wb_fwd_match #(.NS(NS), .AW(AW), .DW(DW)) u_fwd2 (
    .addr       (wb.fwd_addr2),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd),
    .slot_data  (slot_data),
    .hit        (wb.fwd_hit2),
    .data       (wb.fwd_data2)
  );
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_rf_writeback_queue;
  import kgp_risc_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_writeback_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending writes in arrival order plus the output stage.
  wb_entry_t mq[$];
  logic      m_valid;
  wb_entry_t m_out;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_out   = '0;
  endtask

  task automatic drive_idle();
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.hold = 1'b0; bus.flush = 1'b0;
    bus.fwd_addr1 = '0; bus.fwd_addr2 = '0;
  endtask

  // Advances one clock and applies the queue rules to the model.
  task automatic tick();
    wb_entry_t e;
    int  sz;
    bit  do_push;
    bit  do_pop;
    bit  fl;
    sz      = mq.size();
    e.rd    = bus.mem_valid ? bus.mem_reg  : bus.alu_reg;
    e.data  = bus.mem_valid ? bus.mem_data : bus.alu_data;
    fl      = bus.flush;
    do_push = !fl && (sz < DEPTH) && (bus.mem_valid || bus.alu_valid);
    do_pop  = !fl && !bus.hold && (sz > 0);
    @(posedge clk); #1;
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      if (do_pop) begin
        m_out   = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (do_push) mq.push_back(e);
    end
  endtask

  // Newest pending write to addr, searching output stage then queue head to tail.
  function automatic void model_fwd(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (m_valid && m_out.rd == a) begin hit = 1'b1; d = m_out.data; end
    foreach (mq[i]) if (mq[i].rd == a) begin hit = 1'b1; d = mq[i].data; end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", bus.full); end
    tests++; if (bus.reg_write !== 1'b0) begin fails++; $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); end
    tests++; if (bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin fails++; $display("FAIL reset_write_port: got r%0d=%h want r0=0", bus.write_reg, bus.write_data); end
    tests++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin fails++; $display("FAIL reset_fwd_hit: got %b%b want 00", bus.fwd_hit1, bus.fwd_hit2); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL single_alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    drive_idle();
    #1;
    tests++; if (bus.reg_write !== 1'b0 || bus.count !== 3'd1) begin fails++; $display("FAIL single_queued: got we=%b count=%0d want we=0 count=1", bus.reg_write, bus.count); end
    tick();
    tests++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_commit: got we=%b r%0d=%h want we=1 r5=deadbeef", bus.reg_write, bus.write_reg, bus.write_data); end
    tests++; if (bus.count !== 3'd0) begin fails++; $display("FAIL single_count: got %0d want 0", bus.count); end
    tick();
    tests++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd5) begin fails++; $display("FAIL single_idle: got we=%b r%0d want we=0 r5", bus.reg_write, bus.write_reg); end
  endtask

  task automatic test_priority();
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd3; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'h22;
    #1;
    tests++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin fails++; $display("FAIL prio_ready: got mem=%b alu=%b want mem=1 alu=0", bus.mem_ready, bus.alu_ready); end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    tests++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL prio_alu_ready: got %b want 1", bus.alu_ready); end
    tick();
    drive_idle();
    tests++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'h11) begin fails++; $display("FAIL prio_first: got we=%b r%0d=%h want r3=11", bus.reg_write, bus.write_reg, bus.write_data); end
    tick();
    tests++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd4 || bus.write_data !== 32'h22) begin fails++; $display("FAIL prio_second: got we=%b r%0d=%h want r4=22", bus.reg_write, bus.write_reg, bus.write_data); end
    tick();
    tests++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL prio_drained: got we=%b empty=%b want 0/1", bus.reg_write, bus.empty); end
  endtask

  task automatic test_hold_full();
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(i); bus.alu_data = 32'(i);
      tick();
    end
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h99;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd9; bus.mem_data = 32'h99;
    #1;
    tests++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin fails++; $display("FAIL full_flag: got full=%b count=%0d want 1/4", bus.full, bus.count); end
    tests++; if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got mem=%b alu=%b want 0/0", bus.mem_ready, bus.alu_ready); end
    bus.hold = 1'b0;
    #1;
    tests++; if (bus.mem_ready !== 1'b0) begin fails++; $display("FAIL full_no_passthrough: got mem_ready=%b want 0", bus.mem_ready); end
    tick();
    tests++; if (bus.reg_write !== 1'b1 || bus.write_data !== 32'd1 || bus.count !== 3'd3) begin fails++; $display("FAIL drain_1: got we=%b data=%0d count=%0d want 1/1/3", bus.reg_write, bus.write_data, bus.count); end
    drive_idle();
    for (int i = 2; i <= 4; i++) begin
      tick();
      tests++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'(i) || bus.write_data !== 32'(i)) begin fails++; $display("FAIL drain_%0d: got we=%b r%0d=%0d want r%0d=%0d", i, bus.reg_write, bus.write_reg, bus.write_data, i, i); end
    end
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
    tick();
    tests++; if (bus.reg_write !== 1'b0) begin fails++; $display("FAIL drain_stop: got we=%b want 0", bus.reg_write); end
  endtask

  task automatic test_forward_and_flush();
    bus.hold = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'hA; tick();
    bus.alu_data = 32'hB; tick();
    bus.alu_reg = 5'd2; bus.alu_data = 32'h33; tick();
    bus.alu_valid = 1'b0;
    bus.fwd_addr1 = 5'd7; bus.fwd_addr2 = 5'd8;
    #1;
    tests++; if (bus.fwd_hit1 !== 1'b1 || bus.fwd_data1 !== 32'hB) begin fails++; $display("FAIL fwd_newest: got hit=%b data=%h want 1/b", bus.fwd_hit1, bus.fwd_data1); end
    tests++; if (bus.fwd_hit2 !== 1'b0) begin fails++; $display("FAIL fwd_miss: got hit=%b want 0", bus.fwd_hit2); end
    bus.fwd_addr2 = 5'd2;
    #1;
    tests++; if (bus.fwd_hit2 !== 1'b1 || bus.fwd_data2 !== 32'h33) begin fails++; $display("FAIL fwd_port2: got hit=%b data=%h want 1/33", bus.fwd_hit2, bus.fwd_data2); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    #1;
    tests++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.reg_write !== 1'b0) begin fails++; $display("FAIL flush_state: got count=%0d empty=%b we=%b want 0/1/0", bus.count, bus.empty, bus.reg_write); end
    tests++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_hit2 !== 1'b0) begin fails++; $display("FAIL flush_fwd: got %b%b want 00", bus.fwd_hit1, bus.fwd_hit2); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.reg_write !== 1'b0) begin fails++; $display("FAIL flush_no_pulse_%0d: got we=%b want 0", i, bus.reg_write); end
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(10 + i); bus.alu_data = 32'(100 + i);
      tick();
    end
    drive_idle();
    tests++; if (bus.reg_write !== 1'b1 || bus.count !== 3'(mq.size())) begin fails++; $display("FAIL midrst_pre: got we=%b count=%0d want 1/%0d", bus.reg_write, bus.count, mq.size()); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.reg_write !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin fails++; $display("FAIL midrst_async: got we=%b count=%0d empty=%b want 0/0/1", bus.reg_write, bus.count, bus.empty); end
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit          h1, h2;
    logic [DW-1:0] d1, d2;
    for (int c = 0; c < 400; c++) begin
      bus.mem_valid = ($urandom_range(0, 9) < 4);
      bus.mem_reg   = 5'($urandom_range(0, 7));
      bus.mem_data  = $urandom();
      bus.alu_valid = ($urandom_range(0, 9) < 5);
      bus.alu_reg   = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom();
      bus.hold      = ($urandom_range(0, 9) < 3);
      bus.flush     = ($urandom_range(0, 49) == 0);
      bus.fwd_addr1 = 5'($urandom_range(0, 7));
      bus.fwd_addr2 = 5'($urandom_range(0, 7));
      #1;
      model_fwd(bus.fwd_addr1, h1, d1);
      model_fwd(bus.fwd_addr2, h2, d2);
      tests++; if (bus.mem_ready !== (mq.size() < DEPTH) || bus.alu_ready !== ((mq.size() < DEPTH) && !bus.mem_valid)) begin fails++; $display("FAIL rnd_ready c%0d: got mem=%b alu=%b size=%0d", c, bus.mem_ready, bus.alu_ready, mq.size()); end
      tests++; if (bus.fwd_hit1 !== h1 || (h1 && bus.fwd_data1 !== d1)) begin fails++; $display("FAIL rnd_fwd1 c%0d: got %b/%h want %b/%h", c, bus.fwd_hit1, bus.fwd_data1, h1, d1); end
      tests++; if (bus.fwd_hit2 !== h2 || (h2 && bus.fwd_data2 !== d2)) begin fails++; $display("FAIL rnd_fwd2 c%0d: got %b/%h want %b/%h", c, bus.fwd_hit2, bus.fwd_data2, h2, d2); end
      tick();
      tests++; if (bus.reg_write !== m_valid || (m_valid && (bus.write_reg !== m_out.rd || bus.write_data !== m_out.data))) begin fails++; $display("FAIL rnd_commit c%0d: got we=%b r%0d=%h want we=%b r%0d=%h", c, bus.reg_write, bus.write_reg, bus.write_data, m_valid, m_out.rd, m_out.data); end
      tests++; if (bus.count !== 3'(mq.size()) || bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0)) begin fails++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, mq.size()); end
    end
    drive_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_hold_full();
    test_forward_and_flush();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
